seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
Receive-side counterpart of the seven-segment display driver. Samples the multiplexed segment/anode bus of a 4-digit display and recovers the displayed digits. Segment bus is active-low, ordered {g,f,e,d,c,b,a}, so bit 6 is g and bit 0 is a. Anodes are active-high one-hot, and bit i selects digit i. Used for loopback checking of display paths and for sniffing external display boards.

Parameters:
SETTLE_CYCLES, 16, clk cycles a one-hot anode plus segment pattern must stay unchanged before it is sampled; must be >= 1.
TIMEOUT_CYCLES, 100000, cycles without any capture before stale asserts; must be >= 1.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
seg_in  input  7  segment bus, active-low {g..a}; asynchronous to clk.
an_in  input  4  anode bus, active-high; asynchronous to clk.
digits  output  16  last complete frame; digit i in [4i+3:4i].
digit_err  output  4  per-digit flag: 1 means an unrecognised pattern was captured in the last frame.
frame_valid  output  1  one-cycle pulse when digits and digit_err update.
stale  output  1  1 when no capture has occurred for TIMEOUT_CYCLES cycles.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous and active-low. All flops reset asynchronously.
- Reset values:
  - digits = 16'h0000, digit_err = 4'h0, frame_valid = 0, stale = 0.
  - Synchronizer stages: seg = 7'h7F, an = 4'h0.
  - Internal digit store = 0, seen mask = 0, all counters = 0, FSM = IDLE.
- Input path: 2-flop synchronizer on seg_in and an_in. A one-cycle history register holds the previous synchronized {an,seg}.
- Capture FSM:
  - IDLE: synchronized an is not one-hot (0 or more than 1 bits set). Stay here and hold settle_cnt = 0.
  - IDLE -> SETTLING: an becomes one-hot.
  - SETTLING: settle_cnt increments each cycle that {an,seg} equals the history register. Any change resets settle_cnt to 0; the FSM goes to IDLE if an is no longer one-hot, otherwise stays in SETTLING.
  - SETTLING -> HELD: on the cycle settle_cnt == SETTLE_CYCLES-1 and {an,seg} is unchanged, capture.
  - HELD: no further capture until {an,seg} changes. Then go to SETTLING (an one-hot) or IDLE (an not one-hot).
  - Exactly one capture per dwell.
- Latency: pin change to capture is 2 + SETTLE_CYCLES cycles.
- Capture of index i:
  - Decode seg to a 4-bit code and write it to store[i].
  - Recognised patterns (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Unrecognised pattern: store 4'hF and set err[i]=1. Otherwise set err[i]=0.
  - Set seen[i]=1.
  - Recapturing the same index before frame completion overwrites store[i] and err[i].
- Frame completion: when seen (including the current capture) equals 4'hF, on the next cycle:
  - digits <= store, digit_err <= err.
  - frame_valid = 1 for exactly one cycle.
  - seen cleared to 0.
  - A capture in that same cycle sets its seen bit after the clear.
- Stale counter:
  - Counts cycles since the last capture and saturates.
  - stale = 1 while count >= TIMEOUT_CYCLES.
  - Any capture clears the count and deasserts stale on the following cycle.
- Reset mid-dwell or mid-frame: all partial data is discarded. The first frame after reset needs all four digits freshly captured.

Optional Feature:
Macro SEG7_CAPTURE_HEX_EN.
- Defined: the decoder also recognises A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, giving codes 4'hA to 4'hF with err=0.
- Not defined: those patterns are unrecognised, giving code 4'hF with err=1.
- The port list is identical in both builds.

Decomposition:
- Package seg7_pkg:
  - Constants SEG7_0 to SEG7_9, SEG7_A to SEG7_F, and SEG7_BLANK=7'h7F.
  - Constants SEG7_ERR_CODE=4'hF and NUM_DIGITS=4.
  - Capture FSM state enum.
- Sub-module seg7_pattern_decode: combinational; input 7-bit pattern; outputs code[3:0] and valid. It is the only consumer of SEG7_CAPTURE_HEX_EN.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Reset: assert rst_n=0 mid-stream -> digits=0000, digit_err=0, frame_valid=0, stale=0 immediately. No frame_valid until four new captures have occurred.
- Scan: scan an=0001/0010/0100/1000 with patterns for 1,2,3,4, dwell 10 cycles each -> single frame_valid pulse with digits=16'h4321, digit_err=0. Exactly 4 captures total.
- Short dwell: an=0001 held 3 cycles then changed -> no capture for digit 0. Glitch an=0011 -> ignored. Digit 0 is captured only after a full 4-cycle stable dwell.
- Invalid pattern: digit 2 pattern 1111111 -> digits[11:8]=F and digit_err=4'b0100. With SEG7_CAPTURE_HEX_EN and pattern 0001000 -> digits[11:8]=A and digit_err[2]=0.
- Stale: hold an=0000 for 70 cycles -> stale=1 from cycle 64 on. Resume scanning -> stale=0 one cycle after the first capture.
- Overwrite: capture digit 0 = 5, then digit 0 = 7 before digits 1 to 3 complete -> frame shows digits[3:0]=7.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture block.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned CODE_W     = 4;

    localparam logic [SEG_W-1:0] SEG7_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG7_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG7_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG7_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG7_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG7_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG7_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG7_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG7_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG7_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG7_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG7_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG7_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG7_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG7_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG7_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

    localparam logic [CODE_W-1:0] SEG7_ERR_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_HELD     = 2'd2
    } cap_state_e;

    // One synchronized sample of the display bus.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [SEG_W-1:0]      seg;
    } bus_sample_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_DIGITS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[1]) idx = 2'd1;
        if (v[2]) idx = 2'd2;
        if (v[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-code decoder.
// SEG7_CAPTURE_HEX_EN adds recognition of the A..F glyphs.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  i_pattern,
    output logic [CODE_W-1:0] o_code_c,
    output logic              o_valid_c
);

`ifdef SEG7_CAPTURE_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    // Hex glyphs decode to themselves only when enabled, else to the error code.
    always_comb begin
        o_code_c  = SEG7_ERR_CODE;
        o_valid_c = 1'b0;
        case (i_pattern)
            SEG7_0: begin o_code_c = 4'h0; o_valid_c = 1'b1; end
            SEG7_1: begin o_code_c = 4'h1; o_valid_c = 1'b1; end
            SEG7_2: begin o_code_c = 4'h2; o_valid_c = 1'b1; end
            SEG7_3: begin o_code_c = 4'h3; o_valid_c = 1'b1; end
            SEG7_4: begin o_code_c = 4'h4; o_valid_c = 1'b1; end
            SEG7_5: begin o_code_c = 4'h5; o_valid_c = 1'b1; end
            SEG7_6: begin o_code_c = 4'h6; o_valid_c = 1'b1; end
            SEG7_7: begin o_code_c = 4'h7; o_valid_c = 1'b1; end
            SEG7_8: begin o_code_c = 4'h8; o_valid_c = 1'b1; end
            SEG7_9: begin o_code_c = 4'h9; o_valid_c = 1'b1; end
            SEG7_A: begin o_code_c = HEX_EN ? 4'hA : SEG7_ERR_CODE; o_valid_c = HEX_EN; end
            SEG7_B: begin o_code_c = HEX_EN ? 4'hB : SEG7_ERR_CODE; o_valid_c = HEX_EN; end
            SEG7_C: begin o_code_c = HEX_EN ? 4'hC : SEG7_ERR_CODE; o_valid_c = HEX_EN; end
            SEG7_D: begin o_code_c = HEX_EN ? 4'hD : SEG7_ERR_CODE; o_valid_c = HEX_EN; end
            SEG7_E: begin o_code_c = HEX_EN ? 4'hE : SEG7_ERR_CODE; o_valid_c = HEX_EN; end
            SEG7_F: begin o_code_c = SEG7_ERR_CODE;               o_valid_c = HEX_EN; end
            default: ;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers the four digits shown on a multiplexed seven-segment bus.
// Hex glyph recognition is controlled by SEG7_CAPTURE_HEX_EN in the decoder.
module seven_segment_capture
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEG_W-1:0]           seg_in,
    input  logic [NUM_DIGITS-1:0]      an_in,
    output logic [NUM_DIGITS*4-1:0]    digits,
    output logic [NUM_DIGITS-1:0]      digit_err,
    output logic                       frame_valid,
    output logic                       stale
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned STALE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [STALE_W-1:0]  STALE_MAX   = STALE_W'(TIMEOUT_CYCLES);

    logic [SEG_W-1:0]          r_seg_s1, r_seg_s2;
    logic [NUM_DIGITS-1:0]     r_an_s1, r_an_s2;
    bus_sample_t               r_hist;
    cap_state_e                r_state;
    logic [SETTLE_W-1:0]       r_settle_cnt;
    logic [NUM_DIGITS*4-1:0]   r_store, r_digits;
    logic [NUM_DIGITS-1:0]     r_err, r_digit_err, r_seen;
    logic                      r_done_pend, r_frame_valid, r_stale;
    logic [STALE_W-1:0]        r_stale_cnt;

    bus_sample_t               w_cur;
    logic                      w_changed, w_onehot, w_capture, w_code_valid;
    logic [1:0]                w_idx;
    logic [CODE_W-1:0]         w_code;
    logic [NUM_DIGITS-1:0]     w_seen_base, w_seen_next;

    assign w_cur       = {r_an_s2, r_seg_s2};
    assign w_changed   = (w_cur != r_hist);
    assign w_onehot    = is_onehot(r_an_s2);
    assign w_idx       = onehot_to_idx(r_an_s2);
    assign w_capture   = (r_state == ST_SETTLING) && !w_changed && (r_settle_cnt == SETTLE_LAST);
    assign w_seen_base = r_done_pend ? 4'h0 : r_seen;
    assign w_seen_next = w_capture ? (w_seen_base | r_an_s2) : w_seen_base;

    seg7_pattern_decode u_decode (
        .i_pattern (r_seg_s2),
        .o_code_c  (w_code),
        .o_valid_c (w_code_valid)
    );

    // Two-flop synchronizer plus one-cycle history for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= SEG7_BLANK;
            r_seg_s2 <= SEG7_BLANK;
            r_an_s1  <= '0;
            r_an_s2  <= '0;
            r_hist   <= {4'h0, SEG7_BLANK};
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
            r_hist   <= w_cur;
        end
    end

    // Dwell tracker: one capture per stable one-hot dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_settle_cnt <= '0;
                    if (w_onehot) r_state <= ST_SETTLING;
                end
                ST_SETTLING: begin
                    if (w_changed) begin
                        r_settle_cnt <= '0;
                        if (!w_onehot) r_state <= ST_IDLE;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_HELD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_HELD: begin
                    if (w_changed) begin
                        r_settle_cnt <= '0;
                        r_state      <= w_onehot ? ST_SETTLING : ST_IDLE;
                    end
                end
                default: begin
                    r_settle_cnt <= '0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-digit store; a completed frame is published one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store       <= '0;
            r_err         <= '0;
            r_seen        <= '0;
            r_done_pend   <= 1'b0;
            r_digits      <= '0;
            r_digit_err   <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_store[{w_idx, 2'b00} +: 4] <= w_code;
                r_err[w_idx]                 <= ~w_code_valid;
            end
            r_seen        <= w_seen_next;
            r_done_pend   <= w_capture && (w_seen_next == 4'hF);
            r_frame_valid <= r_done_pend;
            if (r_done_pend) begin
                r_digits    <= r_store;
                r_digit_err <= r_err;
            end
        end
    end

    // Saturating cycles-since-capture counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (w_capture) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (r_stale_cnt != STALE_MAX) begin
            r_stale_cnt <= r_stale_cnt + STALE_W'(1);
            r_stale     <= ((r_stale_cnt + STALE_W'(1)) >= STALE_MAX);
        end
    end

    assign digits      = r_digits;
    assign digit_err   = r_digit_err;
    assign frame_valid = r_frame_valid;
    assign stale       = r_stale;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed plus randomized bench for seven_segment_capture against a dwell-level model.
module tb_seven_segment_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;
`ifdef SEG7_CAPTURE_HEX_EN
    localparam int NUM_KNOWN = 16;
`else
    localparam int NUM_KNOWN = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    seven_segment_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // Glyph table: index is the displayed value.
    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_total  = 0;
    int n_pass   = 0;
    int fv_count = 0;

    always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

    // Reference state: what a sniffer should have recovered so far.
    logic [3:0]  m_nib [4];
    logic [3:0]  m_err, m_seen, m_derr;
    logic [15:0] m_digits;
    int          m_frames = 0;

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] code, output logic err);
        code = 4'hF;
        err  = 1'b1;
        for (int k = 0; k < NUM_KNOWN; k++)
            if (pat[k] == s) begin code = 4'(k); err = 1'b0; end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
        m_err = 4'h0; m_seen = 4'h0; m_derr = 4'h0; m_digits = 16'h0;
    endtask

    // A dwell longer than the settle time on a single anode yields one capture.
    task automatic model_dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        int idx;
        logic [3:0] c;
        logic e;
        if ($countones(a) == 1 && len > int'(SETTLE)) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (a[k]) idx = k;
            model_decode(s, c, e);
            m_nib[idx] = c; m_err[idx] = e; m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                m_frames++;
                for (int k = 0; k < 4; k++) m_digits[4*k +: 4] = m_nib[k];
                m_derr = m_err;
                m_seen = 4'h0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        an_in = a; seg_in = s;
        tick(len);
        model_dwell(a, s, len);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_frames"}, 32'(fv_count), 32'(m_frames));
        check({tag, "_digits"}, 32'(digits), 32'(m_digits));
        check({tag, "_err"}, 32'(digit_err), 32'(m_derr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_err"}, 32'(digit_err), 32'h0);
        check({tag, "_fv"}, 32'(frame_valid), 32'h0);
        check({tag, "_stale"}, 32'(stale), 32'h0);
    endtask

    initial begin
        logic [3:0] prev_a;
        logic [6:0] prev_s;

        rst_n = 1'b0; an_in = 4'h0; seg_in = 7'h7F;
        model_reset();
        tick(3);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Stale timeout with anodes idle.
        tick(60);
        check("stale_before", 32'(stale), 32'h0);
        tick(10);
        check("stale_after", 32'(stale), 32'h1);

        // Basic scan 1,2,3,4; first capture clears stale.
        an_in = 4'b0001; seg_in = pat[1];
        tick(3);
        check("stale_pre_capture", 32'(stale), 32'h1);
        tick(7);
        model_dwell(4'b0001, pat[1], 10);
        check("stale_cleared", 32'(stale), 32'h0);
        dwell(4'b0010, pat[2], 10);
        dwell(4'b0100, pat[3], 10);
        dwell(4'b1000, pat[4], 10);
        check_frame("scan");
        check("scan_literal", 32'(digits), 32'h4321);
        check("scan_one_pulse", 32'(fv_count), 32'h1);

        // Short dwell and multi-anode glitch are ignored; invalid glyph on digit 2.
        dwell(4'b0001, pat[5], 3);
        dwell(4'b0011, pat[5], 2);
        dwell(4'b0000, 7'h7F, 2);
        check("short_no_frame", 32'(fv_count), 32'(m_frames));
        dwell(4'b0001, pat[5], 10);
        dwell(4'b0010, pat[6], 10);
        dwell(4'b0100, 7'h7F, 10);
        check("invalid_no_frame", 32'(fv_count), 32'(m_frames));
        dwell(4'b1000, pat[9], 10);
        check_frame("invalid");
        check("invalid_literal", 32'(digits), 32'h9F65);
        check("invalid_err_literal", 32'(digit_err), 32'h4);

        // Hex glyph A on digit 2.
        dwell(4'b0001, pat[0], 10);
        dwell(4'b0010, pat[1], 10);
        dwell(4'b0100, 7'b0001000, 10);
        dwell(4'b1000, pat[2], 10);
        check_frame("hex");
`ifdef SEG7_CAPTURE_HEX_EN
        check("hex_literal", 32'(digits), 32'h2A10);
        check("hex_err_literal", 32'(digit_err), 32'h0);
`else
        check("hex_literal", 32'(digits), 32'h2F10);
        check("hex_err_literal", 32'(digit_err), 32'h4);
`endif

        // Overwrite of digit 0 before frame completes.
        dwell(4'b0001, pat[5], 10);
        dwell(4'b0001, pat[7], 10);
        dwell(4'b0010, pat[8], 10);
        dwell(4'b0100, pat[9], 10);
        check("overwrite_no_frame", 32'(fv_count), 32'(m_frames));
        dwell(4'b1000, pat[0], 10);
        check_frame("overwrite");
        check("overwrite_literal", 32'(digits), 32'h0987);

        // Reset mid-frame and mid-dwell discards partial data.
        dwell(4'b0001, pat[3], 10);
        dwell(4'b0010, pat[4], 10);
        an_in = 4'b0100; seg_in = pat[6];
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        an_in = 4'h0; seg_in = 7'h7F;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        dwell(4'b0100, pat[6], 10);
        dwell(4'b1000, pat[7], 10);
        check("post_reset_no_frame_a", 32'(fv_count), 32'(m_frames));
        dwell(4'b0001, pat[1], 10);
        check("post_reset_no_frame_b", 32'(fv_count), 32'(m_frames));
        dwell(4'b0010, pat[2], 10);
        check_frame("post_reset");
        check("post_reset_literal", 32'(digits), 32'h7621);

        // Randomized dwells.
        prev_a = an_in; prev_s = seg_in;
        for (int r = 0; r < 40; r++) begin
            logic [3:0] a;
            logic [6:0] s;
            int sel, len;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 4'(1 << (sel % 4));
            else if (sel == 8) a = 4'h0;
            else               a = ($urandom_range(0, 1) == 0) ? 4'b0110 : 4'b1111;
            sel = int'($urandom_range(0, 19));
            if (sel < 16) s = pat[sel];
            else          s = 7'($urandom);
            len = ($urandom_range(0, 9) < 7) ? int'($urandom_range(10, 14)) : int'($urandom_range(1, 3));
            if ({a, s} == {prev_a, prev_s}) s = s ^ 7'h01;
            dwell(a, s, len);
            prev_a = a; prev_s = s;
            check_frame("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
